vfifo_sync_ctrl: RTL and testbench

Single-clock FIFO controller that drives the write (A) and read (B) ports of the single-write, registered-read-address dual-port RAM in the versatile FIFO. It owns the write and read pointers, the fill level and the full/empty/almost flags. It also generates a read-data-valid strobe that is aligned to the RAM's one-cycle read latency. Together with the RAM it forms the synchronous FIFO.

---
 rtl/vfifo_sync_ctrl.sv | 87 ++++++++
 tb/tb_vfifo_sync_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/vfifo_sync_ctrl.sv
// rtl/vfifo_sync_ctrl.sv - pointer, flag and strobe controller for the single-clock versatile FIFO
//
// Drives port A (write) and port B (registered read address) of the dual-port RAM.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   wr_en, rd_en      write / read requests from the user
//   ram_we            RAM write enable, high only for an accepted write
//   ram_adr_a         RAM write address (write pointer low bits)
//   ram_adr_b         RAM read address (read pointer low bits)
//   rd_valid          RAM q_b holds the word of the read accepted last cycle
//   full, empty       fill_level == depth / fill_level == 0
//   almost_full       fill_level >= ALMOST_FULL_TH
//   almost_empty      fill_level <= ALMOST_EMPTY_TH
//   fill_level        number of stored words
//   wr_err, rd_err    one-cycle pulses for a rejected write / read
module vfifo_sync_ctrl #(
    parameter int ADDR_WIDTH      = 9,
    parameter int ALMOST_FULL_TH  = 2**ADDR_WIDTH - 2,
    parameter int ALMOST_EMPTY_TH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic                  rd_en,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_adr_a,
    output logic [ADDR_WIDTH-1:0] ram_adr_b,
    output logic                  rd_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   fill_level,
    output logic                  wr_err,
    output logic                  rd_err
);

    localparam logic [ADDR_WIDTH:0] AF_TH = (ADDR_WIDTH+1)'(ALMOST_FULL_TH);
    localparam logic [ADDR_WIDTH:0] AE_TH = (ADDR_WIDTH+1)'(ALMOST_EMPTY_TH);

    // Pointers carry one extra wrap bit so full and empty are distinguishable
    // when the low address bits coincide.
    logic [ADDR_WIDTH:0] wr_ptr;
    logic [ADDR_WIDTH:0] rd_ptr;
    logic                wr_acc;
    logic                rd_acc;

    // Flags are decoded from registered pointers only; requests in the current
    // cycle never reach them combinationally.
    assign fill_level   = wr_ptr - rd_ptr;
    assign empty        = (wr_ptr == rd_ptr);
    assign full         = (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]) &&
                          (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);
    assign almost_full  = (fill_level >= AF_TH);
    assign almost_empty = (fill_level <= AE_TH);

    // A read can only be accepted when at least one word is stored, so the
    // read slot never equals the slot being written in the same cycle.
    assign wr_acc = wr_en & ~full & ~rst;
    assign rd_acc = rd_en & ~empty & ~rst;

    assign ram_we    = wr_acc;
    assign ram_adr_a = wr_ptr[ADDR_WIDTH-1:0];
    assign ram_adr_b = rd_ptr[ADDR_WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            rd_valid <= 1'b0;
            wr_err   <= 1'b0;
            rd_err   <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            // The RAM registers adr_b on this edge, so q_b is valid next cycle.
            rd_valid <= rd_acc;
            wr_err   <= wr_en & full;
            rd_err   <= rd_en & empty;
        end
    end

endmodule

// File: tb/tb_vfifo_sync_ctrl.sv
// tb/tb_vfifo_sync_ctrl.sv - scoreboard bench for vfifo_sync_ctrl with a behavioural RAM
module tb_vfifo_sync_ctrl;

    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic          rd_en;
    logic          ram_we;
    logic [AW-1:0] ram_adr_a;
    logic [AW-1:0] ram_adr_b;
    logic          rd_valid;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic [AW:0]   fill_level;
    logic          wr_err;
    logic          rd_err;

    logic [7:0]    din;
    logic [7:0]    mem [2**AW];
    logic [AW-1:0] adr_b_q;
    logic [7:0]    q_b;

    int n_chk  = 0;
    int n_pass = 0;
    int model_cnt = 0;
    int exp_reads = 0;
    int seen_reads = 0;
    logic [7:0] exp_q [$];

    always #5 clk = ~clk;

    vfifo_sync_ctrl #(
        .ADDR_WIDTH      (AW),
        .ALMOST_FULL_TH  (6),
        .ALMOST_EMPTY_TH (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .rd_en        (rd_en),
        .ram_we       (ram_we),
        .ram_adr_a    (ram_adr_a),
        .ram_adr_b    (ram_adr_b),
        .rd_valid     (rd_valid),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .fill_level   (fill_level),
        .wr_err       (wr_err),
        .rd_err       (rd_err)
    );

    // Dual-port RAM with registered read address.
    always @(posedge clk) begin
        if (ram_we) mem[ram_adr_a] <= din;
        adr_b_q <= ram_adr_b;
    end
    assign q_b = mem[adr_b_q];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // One clock of stimulus. Called just after a falling edge; returns just
    // after the next falling edge with the post-edge state visible.
    task automatic step(input logic r, input logic we, input logic re, input logic [7:0] d);
        bit wa, ra;
        rst = r; wr_en = we; rd_en = re; din = d;
        wa = we && !r && (model_cnt < 8);
        ra = re && !r && (model_cnt > 0);
        if (r) begin
            exp_q.delete();
            model_cnt = 0;
        end else begin
            if (wa) exp_q.push_back(d);
            if (ra) exp_reads++;
            model_cnt = model_cnt + int'(wa) - int'(ra);
        end
        #1;
        chk("ram_we", int'(ram_we), int'(wa));
        @(negedge clk);
        rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    endtask

    // Monitor: every rd_valid must match the oldest outstanding written word.
    initial begin
        forever begin
            @(negedge clk);
            if (rd_valid) begin
                seen_reads++;
                if (exp_q.size() == 0) begin
                    chk("rd_valid_unexpected", 1, 0);
                end else begin
                    chk("q_b_data", int'(q_b), int'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; din = 8'h00;
        @(negedge clk);

        // Reset, idle
        step(1, 0, 0, 8'h00);
        step(1, 0, 0, 8'h00);
        chk("rst_empty", int'(empty), 1);
        chk("rst_full", int'(full), 0);
        chk("rst_fill", int'(fill_level), 0);
        chk("rst_almost_empty", int'(almost_empty), 1);
        chk("rst_almost_full", int'(almost_full), 0);
        chk("rst_rd_valid", int'(rd_valid), 0);
        chk("rst_adr_a", int'(ram_adr_a), 0);
        chk("rst_adr_b", int'(ram_adr_b), 0);

        // Fill
        for (int i = 0; i < 8; i++) begin
            chk("fill_adr_a", int'(ram_adr_a), i);
            step(0, 1, 0, 8'hA0 + 8'(i));
            chk("fill_level", int'(fill_level), i + 1);
            chk("fill_almost_full", int'(almost_full), (i + 1 >= 6) ? 1 : 0);
        end
        chk("fill_full", int'(full), 1);
        step(0, 1, 0, 8'hEE);
        chk("overflow_wr_err", int'(wr_err), 1);
        chk("overflow_fill", int'(fill_level), 8);
        step(0, 0, 0, 8'h00);
        chk("wr_err_one_cycle", int'(wr_err), 0);

        // Drain
        for (int i = 0; i < 8; i++) begin
            chk("drain_adr_b", int'(ram_adr_b), i);
            step(0, 0, 1, 8'h00);
            chk("drain_rd_valid", int'(rd_valid), 1);
            chk("drain_fill", int'(fill_level), 7 - i);
            chk("drain_almost_empty", int'(almost_empty), (7 - i <= 2) ? 1 : 0);
        end
        chk("drain_empty", int'(empty), 1);
        step(0, 0, 1, 8'h00);
        chk("underflow_rd_err", int'(rd_err), 1);
        chk("underflow_rd_valid", int'(rd_valid), 0);
        step(0, 0, 0, 8'h00);
        chk("rd_err_one_cycle", int'(rd_err), 0);

        // Wrap plus concurrency: pointers start at 0 after the drain.
        for (int i = 0; i < 5; i++) step(0, 1, 0, 8'h10 + 8'(i));
        for (int i = 0; i < 5; i++) step(0, 0, 1, 8'h00);
        for (int i = 0; i < 6; i++) begin
            chk("wrap_adr_a", int'(ram_adr_a), (5 + i) % 8);
            step(0, 1, 0, 8'h20 + 8'(i));
        end
        chk("wrap_fill", int'(fill_level), 6);
        for (int i = 0; i < 20; i++) begin
            step(0, 1, 1, 8'h40 + 8'(i));
            chk("concurrent_fill", int'(fill_level), 6);
        end

        // Boundary simultaneity at full
        step(0, 1, 0, 8'h60);
        step(0, 1, 0, 8'h61);
        chk("bnd_full", int'(full), 1);
        step(0, 1, 1, 8'h62);
        chk("bnd_full_wr_err", int'(wr_err), 1);
        chk("bnd_full_fill", int'(fill_level), 7);

        // Boundary simultaneity at empty
        for (int i = 0; i < 7; i++) step(0, 0, 1, 8'h00);
        chk("bnd_empty", int'(empty), 1);
        step(0, 1, 1, 8'h70);
        chk("bnd_empty_rd_err", int'(rd_err), 1);
        chk("bnd_empty_fill", int'(fill_level), 1);

        // Mid-operation reset
        for (int i = 0; i < 3; i++) step(0, 1, 0, 8'h80 + 8'(i));
        chk("pre_rst_fill", int'(fill_level), 4);
        step(1, 1, 1, 8'hFF);
        chk("mid_rst_empty", int'(empty), 1);
        chk("mid_rst_fill", int'(fill_level), 0);
        chk("mid_rst_adr_a", int'(ram_adr_a), 0);
        chk("mid_rst_adr_b", int'(ram_adr_b), 0);
        chk("mid_rst_rd_valid", int'(rd_valid), 0);

        step(0, 0, 0, 8'h00);
        step(0, 0, 0, 8'h00);
        chk("reads_seen", seen_reads, exp_reads);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
